// File: rtl/sign_narrow_if.sv
// sign_narrow_if: streaming handshake bundle for the sign_narrow unit.
// The slave modport is the narrowing unit; the master modport is the
// producer/consumer side that feeds words in and drains narrowed results.
interface sign_narrow_if #(
    parameter int CNT_W = 8
);
    logic             InValid;
    logic             InReady;
    logic             SignedConst;
    logic [31:0]      In;
    logic             OutValid;
    logic             OutReady;
    logic [15:0]      Out;
    logic             OutOvf;
    logic [CNT_W-1:0] OvfCount;
    logic             Clear;

    modport slave (
        input  InValid,
        input  SignedConst,
        input  In,
        input  OutReady,
        input  Clear,
        output InReady,
        output OutValid,
        output Out,
        output OutOvf,
        output OvfCount
    );

    modport master (
        output InValid,
        output SignedConst,
        output In,
        output OutReady,
        output Clear,
        input  InReady,
        input  OutValid,
        input  Out,
        input  OutOvf,
        input  OvfCount
    );
endinterface

// File: rtl/sign_narrow.sv
// sign_narrow: 32-to-16-bit narrowing unit with range check, a small
// output FIFO and a sticky saturating overflow counter.
// Build option: define SIGN_NARROW_SATURATE_EN to clamp out-of-range words
// to the nearest representable 16-bit value; otherwise they are truncated.
module sign_narrow #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    sign_narrow_if.slave  bus
);
    localparam int           AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [16:0]      r_Mem [FIFO_DEPTH];
    logic [AW-1:0]    r_WrPtr;
    logic [AW-1:0]    r_RdPtr;
    logic [AW:0]      r_Count;
    logic [CNT_W-1:0] r_OvfCount;

    logic             w_InReady;
    logic             w_OutValid;
    logic             w_Accept;
    logic             w_Pop;
    logic             w_Fits;
    logic             w_Ovf;
    logic [15:0]      w_Result;
    logic [AW:0]      w_CountNext;
    logic [16:0]      w_Head;

    assign w_InReady  = (r_Count < DEPTH_C);
    assign w_OutValid = (r_Count != '0);
    assign w_Accept   = bus.InValid && w_InReady;
    assign w_Pop      = w_OutValid && bus.OutReady;
    assign w_Head     = r_Mem[r_RdPtr];

    // Range check: signed words fit when the top 17 bits agree, unsigned when the top 16 are zero
    always_comb begin
        w_Fits = 1'b0;
        if (bus.SignedConst) begin
            w_Fits = (&bus.In[31:15]) || !(|bus.In[31:15]);
        end else begin
            w_Fits = !(|bus.In[31:16]);
        end
    end

    assign w_Ovf = !w_Fits;

    // Pick the 16-bit result: either clamp or plain truncation for out-of-range words
    always_comb begin
        w_Result = bus.In[15:0];
`ifdef SIGN_NARROW_SATURATE_EN
        if (w_Ovf) begin
            if (bus.SignedConst) begin
                w_Result = bus.In[31] ? 16'h8000 : 16'h7FFF;
            end else begin
                w_Result = 16'hFFFF;
            end
        end
`endif
    end

    // Occupancy tracking; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_CountNext = r_Count;
        case ({w_Accept, w_Pop})
            2'b10:   w_CountNext = r_Count + (AW+1)'(1);
            2'b01:   w_CountNext = r_Count - (AW+1)'(1);
            default: w_CountNext = r_Count;
        endcase
    end

    // FIFO storage is not reset; stale entries are never visible because count gates the head
    always_ff @(posedge Clk) begin
        if (w_Accept) begin
            r_Mem[r_WrPtr] <= {w_Ovf, w_Result};
        end
    end

    // Pointers and count; pointers wrap naturally because depth is a power of two
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Count <= '0;
        end else begin
            if (w_Accept) begin
                r_WrPtr <= r_WrPtr + AW'(1);
            end
            if (w_Pop) begin
                r_RdPtr <= r_RdPtr + AW'(1);
            end
            r_Count <= w_CountNext;
        end
    end

    // Sticky overflow counter: clear wins over an increment, and it saturates at all-ones
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_OvfCount <= '0;
        end else if (bus.Clear) begin
            r_OvfCount <= '0;
        end else if (w_Accept && w_Ovf && !(&r_OvfCount)) begin
            r_OvfCount <= r_OvfCount + CNT_W'(1);
        end
    end

    assign bus.InReady  = w_InReady;
    assign bus.OutValid = w_OutValid;
    assign bus.Out      = w_OutValid ? w_Head[15:0] : 16'h0000;
    assign bus.OutOvf   = w_OutValid ? w_Head[16]   : 1'b0;
    assign bus.OvfCount = r_OvfCount;
endmodule

// File: doc/sign_narrow.md
# sign_narrow

Streaming 32-to-16-bit narrowing unit: the inverse of the datapath's 16-to-32 sign/zero extension. It accepts 32-bit words over a valid/ready handshake and checks whether each word can be represented as a sign-extended (signed mode) or zero-extended (unsigned mode) 16-bit value. It emits the 16-bit result with an overflow flag through a small output FIFO. It sits between the ALU result path and halfword store/immediate-packing logic, and keeps a sticky overflow count for debug.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO entries; power of two, minimum 2.
- CNT_W, 8: width of the overflow counter.

Ports:
- Clk  in  1  clock, rising-edge.
- Rst  in  1  reset; one clock; reset is asynchronous and active-low.
- InValid  in  1  input word present.
- InReady  out  1  unit can accept this cycle.
- SignedConst  in  1  1 = signed range check, 0 = unsigned; sampled with In.
- In  in  32  word to narrow.
- OutValid  out  1  FIFO head valid.
- OutReady  in  1  consumer takes head this cycle.
- Out  out  16  narrowed value at FIFO head.
- OutOvf  out  1  head word was out of range.
- OvfCount  out  CNT_W  saturating count of accepted out-of-range words.
- Clear  in  1  synchronous clear of OvfCount.

## Operation
- Accept = InValid && InReady. Pop = OutValid && OutReady.
- InReady = (count < FIFO_DEPTH). It does not depend on OutReady, so there is no pass-through when full.
- Range check on accept:
  - Signed: fits iff In[31:15] is all 0s or all 1s.
  - Unsigned: fits iff In[31:16] == 0.
  - ovf = !fits.
- Result when fits: Out = In[15:0].
- Result when ovf: see Configuration.
- FIFO entry = {ovf, result}. Write pointer advances on accept, read pointer on pop. Pointers wrap modulo FIFO_DEPTH. Count is tracked with one extra bit.
- Simultaneous accept and pop: count unchanged. Both pointers advance. Legal at any non-full count, including empty→(push only).
- OutValid = (count != 0). Out and OutOvf = head entry when valid, and 0 when empty.
- OvfCount: +1 on each accepted ovf word and saturates at all-ones.
  - Clear has priority: Clear together with an ovf accept yields 0.
- Invariant: for non-overflow words, extending Out by SignedConst reproduces In exactly.

## Timing
- Reset (asynchronous assert, synchronous release): pointers, count, and OvfCount = 0. OutValid = 0, Out = 0, OutOvf = 0, InReady = 1. FIFO contents are discarded.
- Reset mid-stream drops all buffered words; there is no partial output.
- Latency: a word accepted at edge N appears at the head with OutValid = 1 after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: 1 word/cycle while OutReady is held high.
- Full: InReady goes low in the cycle after the FIFO_DEPTH-th un-popped accept. It returns high in the cycle after a pop.
- OvfCount updates at the accept edge, the same edge as the FIFO write.
- Out, OutOvf, and OutValid are stable while OutValid && !OutReady.

## Configuration
- SIGN_NARROW_SATURATE_EN defined: out-of-range words clamp.
  - Signed: In[31] = 0 → 0x7FFF; In[31] = 1 → 0x8000.
  - Unsigned: 0xFFFF.
- Not defined: out-of-range words truncate, Out = In[15:0].
- OutOvf and OvfCount behave identically in both builds.

## Test plan
- Reset then signed 0xFFFF8000 and 0x00007FFF with OutReady = 1 → Out 0x8000 and 0x7FFF, OutOvf = 0, 1-cycle latency, OvfCount = 0.
- Signed 0x00008000 → OutOvf = 1, OvfCount = 1. Out = 0x7FFF with SIGN_NARROW_SATURATE_EN, 0x8000 without.
- Unsigned 0x0000FFFF → Out 0xFFFF, ovf 0. Unsigned 0xFFFFFFFF → ovf 1, Out 0xFFFF (both builds).
- OutReady = 0, push 5 words with FIFO_DEPTH = 4 → InReady low after the 4th accept and the 5th is held. Raise OutReady → words pop in order, 5th accepted the cycle after the first pop, pointers wrap correctly.
- Feed 300 ovf words with CNT_W = 8 → OvfCount sticks at 255. Clear in the same cycle as an ovf accept → OvfCount = 0.
- Drop Rst with 3 words buffered → OutValid = 0, InReady = 1, OvfCount = 0 immediately, without waiting for a clock edge.
